// File: rtl/ramp_pkg.sv
// Shared types and helpers for the ramp sweep generator.
package ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_t;

    typedef enum logic {
        SAWTOOTH = 1'b0,
        TRIANGLE = 1'b1
    } sweep_mode_t;

    // Largest duty code representable in a width-bit counter.
    function automatic int unsigned duty_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/ramp_sweep_generator_pwm_core.sv
// PWM period counter with wrap strobe and registered duty compare.
module pwm_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             wrap_c,
    output logic             pwm_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    assign wrap_c = (cnt_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_o <= (cnt_q < duty_i);
        end
    end

endmodule

// File: rtl/ramp_sweep_generator.sv
// Sawtooth/triangle duty-code sweeper driving a PWM output and an R2R DAC code,
// with sweep start/done strobes aligned to the registered outputs.
module ramp_sweep_generator
    import ramp_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned HOLD_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             triangle_mode,
    output logic             pwm_out,
    output logic [WIDTH-1:0] r2r_out,
    output logic [WIDTH-1:0] current_duty_cycle,
    output logic             sweep_start,
    output logic             sweep_done
);

    localparam int unsigned      HOLD_W    = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [WIDTH-1:0] DUTY_MAX  = WIDTH'(duty_max(WIDTH));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    sweep_state_t      state_q, state_d;
    sweep_mode_t       mode_q, mode_d;
    logic [WIDTH-1:0]  duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              first_q, first_d;
    logic [WIDTH-1:0]  code_q;
    logic              start_q, done_q;
    logic              wrap_c, step_c, clr_c, done_c;

    pwm_core #(
        .WIDTH (WIDTH)
    ) u_pwm_core (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (clr_c),
        .duty_i (duty_q),
        .wrap_c (wrap_c),
        .pwm_o  (pwm_out)
    );

    assign step_c = wrap_c && (hold_q == HOLD_LAST);

    // Sweep FSM: duty only moves on a PWM period boundary after the final hold.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        first_d = 1'b0;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = UP;
                    mode_d  = sweep_mode_t'(triangle_mode);
                    first_d = 1'b1;
                end
            end
            UP: begin
                if (step_c) begin
                    if (duty_q != DUTY_MAX) begin
                        duty_d = duty_q + WIDTH'(1);
                    end else if (mode_q == TRIANGLE) begin
                        state_d = DOWN;
                        duty_d  = DUTY_MAX - WIDTH'(1);
                    end else begin
                        duty_d  = '0;
                        done_c  = 1'b1;
                        first_d = 1'b1;
                        mode_d  = sweep_mode_t'(triangle_mode);
                    end
                end
            end
            DOWN: begin
                if (step_c) begin
                    if (duty_q != '0) begin
                        duty_d = duty_q - WIDTH'(1);
                    end else begin
                        state_d = UP;
                        duty_d  = WIDTH'(1);
                        done_c  = 1'b1;
                        first_d = 1'b1;
                        mode_d  = sweep_mode_t'(triangle_mode);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && wrap_c) begin
            hold_d = step_c ? '0 : hold_q + HOLD_W'(1);
        end

        // Dropping enable aborts the sweep silently and clears all progress.
        if ((state_q != IDLE) && !enable) begin
            state_d = IDLE;
            mode_d  = mode_q;
            duty_d  = '0;
            hold_d  = '0;
            first_d = 1'b0;
            done_c  = 1'b0;
        end

        clr_c = (state_q == IDLE) || (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= SAWTOOTH;
            duty_q  <= '0;
            hold_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end

    // Output stage shares the one-clock delay of the registered PWM compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            code_q  <= duty_q;
            start_q <= first_q && (state_q != IDLE);
            done_q  <= done_c;
        end
    end

    assign current_duty_cycle = code_q;
    assign r2r_out            = code_q;
    assign sweep_start        = start_q;
    assign sweep_done         = done_q;

endmodule
